sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Synthesizable responder for the external 16-bit asynchronous SRAM pin interface; the device-side counterpart to the SRAM controller.
- Holds a word-addressed memory array and answers the same SRAM_* pins the controller drives. Reads honour a configurable latency; writes honour byte-lane masks.
- Used as the on-chip SRAM stand-in for system simulation and FPGA bring-up.
- Adds a backdoor port for preload/inspection, plus saturating access counters and a sticky alias flag.

Parameters:
- ADDR_W, 18, SRAM_ADDR width
- DATA_W, 16, SRAM_DQ width; must be 16, one bit per byte lane
- DEPTH_LOG2, 12, implemented words = 2**DEPTH_LOG2; ADDR bits above this alias
- READ_LATENCY, 0, cycles from read address to valid DQ, range 0..3; 0 means combinational (async SRAM)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- SRAM_DQ  inout  16  bidirectional data; driven only during valid reads, else high-Z
- SRAM_ADDR  in  18  word address
- SRAM_UB_N  in  1  upper-byte enable, active-low
- SRAM_LB_N  in  1  lower-byte enable, active-low
- SRAM_WE_N  in  1  write enable, active-low
- SRAM_CE_N  in  1  chip enable, active-low
- SRAM_OE_N  in  1  output enable, active-low
- bd_we  in  1  backdoor write strobe
- bd_addr  in  DEPTH_LOG2  backdoor word address
- bd_wdata  in  16  backdoor write data
- bd_rdata  out  16  backdoor read data, registered, 1-cycle latency
- wr_count  out  16  bus write cycles, saturating
- rd_count  out  16  bus read cycles, saturating
- alias_err  out  1  sticky: a bus access used nonzero ADDR bits above DEPTH_LOG2

Behaviour:
- Reset (rst=0 at posedge):
  - wr_count, rd_count, alias_err, bd_rdata go to 0; state goes to S_IDLE; read pipeline is flushed (valid bits 0); DQ is high-Z.
  - Memory array is NOT cleared.
- Bus decode, every cycle:
  - WR when CE_N=0 and WE_N=0. WE dominates OE, so OE_N=0 during a write is legal and not flagged.
  - RD when CE_N=0, WE_N=1, OE_N=0.
  - Otherwise IDLE.
- State register holds the registered decode: S_IDLE, S_RD, S_WR. A transition may occur on any cycle; no illegal transitions.
- Write: at posedge in WR, for mem[ADDR[DEPTH_LOG2-1:0]]:
  - DQ[7:0] is written iff LB_N=0; DQ[15:8] is written iff UB_N=0.
  - Both lanes masked means no change, but the cycle still counts.
  - wr_count increments, saturating at 16'hFFFF.
- Read, READ_LATENCY=0: DQ = mem[ADDR] combinationally while in RD. rd_count increments at each posedge in RD.
- Read, READ_LATENCY=N>0:
  - Address and RD qualifier go into an N-stage shift pipeline.
  - DQ is driven with the stage-N data only when the stage-N valid bit is 1 AND the current cycle is RD. Otherwise DQ is high-Z.
  - A read of an address written in the same cycle returns the old data (read-before-write at the array).
- Lane tri-state: a lane with its byte enable high is high-Z even during a read.
- alias_err sets at posedge when WR or RD and ADDR[ADDR_W-1:DEPTH_LOG2] != 0. It clears only on reset.
- Backdoor:
  - bd_rdata <= mem[bd_addr] every cycle.
  - bd_we writes the full word.
  - If the bus writes the same address in the same cycle, the bus write wins.
- Reset in mid-read: DQ releases to high-Z in the reset cycle; the pipeline restarts empty.
- Counters change only on real bus cycles; backdoor accesses never count.

Decomposition:
- Shared package holds:
  - state encoding S_IDLE=2'd0, S_RD=2'd1, S_WR=2'd2
  - SRAM_ADDR_W=18 and SRAM_DATA_W=16, shared with the SRAM controller
  - MAX_READ_LATENCY=3
- One sub-module, sram_read_pipe: parameterised N-stage valid/address/data shift register with synchronous active-low reset. For N=0 it is a pass-through.

Test Plan:
- Reset, then backdoor preload mem[0..3]=16'h1111,2222,3333,4444; bus reads 0..3 with READ_LATENCY=0 -> DQ shows each value in the same cycle; rd_count=4.
- Full-word write at addr 5 of 16'hABCD, then UB_N=1,LB_N=0 write of 16'h1234 -> mem[5]=16'hAB34 via bd_rdata; wr_count=2.
- READ_LATENCY=2: read addr 1 held for 3 cycles -> DQ high-Z for 2 cycles, 16'h2222 in the 3rd; high-Z as soon as OE_N=1.
- Access with ADDR=18'h01005 at DEPTH_LOG2=12 -> alias_err=1 and hits mem[5]; flag stays 1 through 10 idle cycles and clears only after rst=0.
- Bus write 16'h00FF and bd_we 16'hFF00 to addr 7 in the same cycle -> mem[7]=16'h00FF. Apply rst=0 during an active read -> DQ high-Z, counters 0, mem[7] retained.
- Issue 65540 write cycles -> wr_count holds at 16'hFFFF.

Source files
------------

// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM responder and its controller-side peer.
// Holds the pin-interface widths, the bus-cycle state encoding and the
// maximum supported read latency.
package sram_responder_pkg;

    localparam int SRAM_ADDR_W      = 18;
    localparam int SRAM_DATA_W      = 16;
    localparam int MAX_READ_LATENCY = 3;

    // Registered decode of the bus pins for the current cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

endpackage

// File: rtl/sram_read_pipe.sv
// N-stage read pipeline: shifts a read-qualifier valid bit and the data
// fetched from the array when the read address was presented.
// Ports:
//   clk, rst        clock, synchronous active-low reset (flushes valid bits)
//   in_valid        read qualifier for the current cycle
//   in_data         array word for the current read address
//   out_valid       valid bit of the last stage
//   out_data        data of the last stage
// For N=0 the block is a combinational pass-through.
// Only the fetched word is carried: the array is read as the address enters,
// so later writes to that word cannot disturb a read already in flight.
module sram_read_pipe #(
    parameter int N  = 0,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    generate
        if (N == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst};
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_pipe
            logic [N-1:0]  vld;
            logic [DW-1:0] dat [N];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    vld <= '0;
                end else begin
                    vld[0] <= in_valid;
                    for (int i = 1; i < N; i++) begin
                        vld[i] <= vld[i-1];
                    end
                end
            end

            // Data stages need no reset: they are only observed behind vld.
            always_ff @(posedge clk) begin
                dat[0] <= in_data;
                for (int i = 1; i < N; i++) begin
                    dat[i] <= dat[i-1];
                end
            end

            assign out_valid = vld[N-1];
            assign out_data  = dat[N-1];
        end
    endgenerate

endmodule

// File: rtl/sram_responder.sv
// Device-side model of a 16-bit asynchronous SRAM answering the SRAM_* pins.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   SRAM_DQ                  bidirectional data, driven only on valid reads
//   SRAM_ADDR                word address (bits above DEPTH_LOG2 alias)
//   SRAM_UB_N/SRAM_LB_N      byte-lane enables, active-low
//   SRAM_WE_N/CE_N/OE_N      write, chip and output enables, active-low
//   bd_we/bd_addr/bd_wdata   backdoor full-word write
//   bd_rdata                 backdoor read, registered, 1-cycle latency
//   wr_count/rd_count        saturating bus write/read cycle counters
//   alias_err                sticky: bus access used nonzero upper ADDR bits
//   dbg_state                registered bus decode (S_IDLE/S_RD/S_WR)
// Handshake: there is none; every posedge with CE_N=0 is one bus cycle.
// WE_N=0 makes it a write regardless of OE_N; otherwise OE_N=0 makes it a
// read. Read data appears READ_LATENCY cycles after the address while the
// read is still being held.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int ADDR_W       = SRAM_ADDR_W,
    parameter int DATA_W       = SRAM_DATA_W,
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire logic [DATA_W-1:0] SRAM_DQ,
    input  logic [ADDR_W-1:0]     SRAM_ADDR,
    input  logic                  SRAM_UB_N,
    input  logic                  SRAM_LB_N,
    input  logic                  SRAM_WE_N,
    input  logic                  SRAM_CE_N,
    input  logic                  SRAM_OE_N,
    input  logic                  bd_we,
    input  logic [DEPTH_LOG2-1:0] bd_addr,
    input  logic [DATA_W-1:0]     bd_wdata,
    output logic [DATA_W-1:0]     bd_rdata,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count,
    output logic                  alias_err,
    output logic [1:0]            dbg_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] word_addr;
    logic                  upper_set;

    state_t state, state_next;
    logic   is_wr, is_rd;

    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;
    logic              drive;

    assign word_addr = SRAM_ADDR[DEPTH_LOG2-1:0];
    assign upper_set = |SRAM_ADDR[ADDR_W-1:DEPTH_LOG2];

    // Bus decode; WE dominates OE.
    always_comb begin
        state_next = S_IDLE;
        is_wr      = 1'b0;
        is_rd      = 1'b0;
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            state_next = S_WR;
            is_wr      = 1'b1;
        end else if (!SRAM_CE_N && !SRAM_OE_N) begin
            state_next = S_RD;
            is_rd      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign dbg_state = state;

    // Counters and sticky alias flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_count  <= 16'd0;
            rd_count  <= 16'd0;
            alias_err <= 1'b0;
        end else begin
            if (is_wr && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
            if (is_rd && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
            if ((is_wr || is_rd) && upper_set) begin
                alias_err <= 1'b1;
            end
        end
    end

    // Array writes: the bus write is scheduled last so it wins over a
    // backdoor write to the same word in the same cycle.
    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end
        if (is_wr) begin
            if (!SRAM_LB_N) begin
                mem[word_addr][7:0] <= SRAM_DQ[7:0];
            end
            if (!SRAM_UB_N) begin
                mem[word_addr][15:8] <= SRAM_DQ[15:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bd_rdata <= '0;
        end else begin
            bd_rdata <= mem[bd_addr];
        end
    end

    sram_read_pipe #(
        .N  (READ_LATENCY),
        .DW (DATA_W)
    ) u_read_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (is_rd),
        .in_data   (mem[word_addr]),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    // Drive only while a read is still on the pins and its data has arrived;
    // reset releases the bus immediately.
    assign drive = rst && is_rd && pipe_valid;

    assign SRAM_DQ[7:0]  = (drive && !SRAM_LB_N) ? pipe_data[7:0]  : 8'bz;
    assign SRAM_DQ[15:8] = (drive && !SRAM_UB_N) ? pipe_data[15:8] : 8'bz;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: one instance at READ_LATENCY=0 and one at
// READ_LATENCY=2 share every bus and backdoor input. The DQ nets carry
// pull-ups, so an undriven lane reads back as 8'hFF.
module tb_sram_responder;

  logic        clk;
  logic        rst;
  logic [17:0] addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [15:0] bd_wdata;
  logic        tb_drv;
  logic [15:0] tb_dq;

  wire  [15:0] dq0, dq1;
  logic [15:0] bd_rdata0, bd_rdata1, wr_count0, wr_count1, rd_count0, rd_count1;
  logic        alias0, alias1;
  logic [1:0]  st0, st1;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [15:0] HIZ = 16'hFFFF;

  assign dq0 = tb_drv ? tb_dq : 16'hzzzz;
  assign dq1 = tb_drv ? tb_dq : 16'hzzzz;

  for (genvar g = 0; g < 16; g++) begin : g_pull
    pullup (dq0[g]);
    pullup (dq1[g]);
  end

  sram_responder #(.READ_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq0), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata0),
    .wr_count(wr_count0), .rd_count(rd_count0), .alias_err(alias0), .dbg_state(st0)
  );

  sram_responder #(.READ_LATENCY(2)) dut1 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata1),
    .wr_count(wr_count1), .rd_count(rd_count1), .alias_err(alias1), .dbg_state(st1)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] addr;
    logic        ub_n;
    logic        lb_n;
    logic [15:0] exp_dq;
  } rd_vec_t;

  rd_vec_t     vecs [6];
  logic [15:0] pre  [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic bus_idle();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
    tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [17:0] a, input logic u, input logic l);
    addr = a; ub_n = u; lb_n = l; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic bus_write(input logic [17:0] a, input logic u, input logic l, input logic [15:0] d);
    addr = a; ub_n = u; lb_n = l; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    tb_drv = 1'b1; tb_dq = d;
  endtask

  initial begin
    rst = 1'b0; addr = '0; bd_we = 1'b0; bd_addr = '0; bd_wdata = '0; tb_dq = '0;
    bus_idle();

    pre[0] = 16'h1111; pre[1] = 16'h2222; pre[2] = 16'h3333; pre[3] = 16'h4444;
    vecs[0] = '{18'd0, 1'b0, 1'b0, 16'h1111};
    vecs[1] = '{18'd1, 1'b0, 1'b0, 16'h2222};
    vecs[2] = '{18'd2, 1'b0, 1'b0, 16'h3333};
    vecs[3] = '{18'd3, 1'b0, 1'b0, 16'h4444};
    vecs[4] = '{18'd2, 1'b1, 1'b0, 16'hFF33};
    vecs[5] = '{18'd3, 1'b0, 1'b1, 16'h44FF};

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_dq0", dq0, HIZ);
    chk("rst_dq1", dq1, HIZ);
    chk("rst_wr_count", wr_count0, 16'd0);
    chk("rst_rd_count", rd_count0, 16'd0);
    chk("rst_alias", 16'(alias0), 16'd0);
    chk("rst_bd_rdata", bd_rdata0, 16'd0);
    chk("rst_state", 16'(st0), 16'd0);
    tick();
    rst = 1'b1;

    // Backdoor preload
    for (int i = 0; i < 4; i++) begin
      bd_we = 1'b1; bd_addr = 12'(i); bd_wdata = pre[i];
      tick();
    end
    bd_we = 1'b0;

    // Table-driven zero-latency reads, including masked lanes
    for (int i = 0; i < 6; i++) begin
      bus_read(vecs[i].addr, vecs[i].ub_n, vecs[i].lb_n);
      @(negedge clk);
      chk($sformatf("rd_vec%0d", i), dq0, vecs[i].exp_dq);
      tick();
    end
    bus_idle();
    @(negedge clk);
    chk("rd_count_after_table", rd_count0, 16'd6);
    chk("rd_count_lat2", rd_count1, 16'd6);
    chk("wr_count_backdoor_only", wr_count0, 16'd0);
    chk("state_after_read", 16'(st0), 16'd1);
    tick();

    // Full write, then lower-lane write with OE_N low (WE dominates)
    bus_write(18'd5, 1'b0, 1'b0, 16'hABCD);
    tick();
    bus_write(18'd5, 1'b1, 1'b0, 16'h1234);
    oe_n = 1'b0;
    tick();
    bus_idle();
    bd_addr = 12'd5;
    @(negedge clk);
    chk("state_after_write", 16'(st0), 16'd2);
    tick();
    @(negedge clk);
    chk("lane_write_mem5", bd_rdata0, 16'hAB34);
    chk("wr_count_two", wr_count0, 16'd2);
    chk("no_alias_yet", 16'(alias0), 16'd0);
    tick();

    // Two-cycle latency read held three cycles, then OE released
    bus_read(18'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat2_c0", dq1, HIZ);
    chk("lat0_same_cycle", dq0, 16'h2222);
    tick();
    @(negedge clk);
    chk("lat2_c1", dq1, HIZ);
    tick();
    @(negedge clk);
    chk("lat2_c2", dq1, 16'h2222);
    tick();
    oe_n = 1'b1;
    @(negedge clk);
    chk("lat2_oe_off", dq1, HIZ);
    tick();
    bus_idle();

    // Aliased access hits mem[5] and sets the sticky flag
    bus_read(18'h01005, 1'b0, 1'b0);
    @(negedge clk);
    chk("alias_read_data", dq0, 16'hAB34);
    tick();
    bus_idle();
    addr = '0;
    @(negedge clk);
    chk("alias_set", 16'(alias0), 16'd1);
    repeat (10) tick();
    @(negedge clk);
    chk("alias_sticky", 16'(alias0), 16'd1);
    tick();

    // Bus write and backdoor write to the same word in one cycle
    bus_write(18'd7, 1'b0, 1'b0, 16'h00FF);
    bd_we = 1'b1; bd_addr = 12'd7; bd_wdata = 16'hFF00;
    tick();
    bus_idle();
    bd_we = 1'b0;
    tick();
    @(negedge clk);
    chk("bus_wins_mem7", bd_rdata0, 16'h00FF);
    tick();

    // Reset during an active read
    bus_read(18'd7, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_dq0", dq0, 16'h00FF);
    tick(); tick();
    @(negedge clk);
    chk("pre_rst_dq1", dq1, 16'h00FF);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_dq0", dq0, HIZ);
    chk("mid_rst_dq1", dq1, HIZ);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_wr_count", wr_count0, 16'd0);
    chk("post_rst_rd_count", rd_count0, 16'd0);
    chk("post_rst_rd_count_lat2", rd_count1, 16'd0);
    chk("post_rst_alias", 16'(alias0), 16'd0);
    chk("post_rst_lat2_empty0", dq1, HIZ);
    chk("post_rst_lat0_dq", dq0, 16'h00FF);
    tick();
    @(negedge clk);
    chk("post_rst_lat2_empty1", dq1, HIZ);
    tick();
    @(negedge clk);
    chk("post_rst_lat2_data", dq1, 16'h00FF);
    tick();
    bus_idle();
    bd_addr = 12'd7;
    tick();
    @(negedge clk);
    chk("mem7_retained", bd_rdata0, 16'h00FF);
    tick();

    // Write counter saturation with both lanes masked
    bus_write(18'd9, 1'b1, 1'b1, 16'h5A5A);
    repeat (65534) tick();
    @(negedge clk);
    chk("wr_count_fffe", wr_count0, 16'hFFFE);
    repeat (6) tick();
    @(negedge clk);
    chk("wr_count_sat", wr_count0, 16'hFFFF);
    chk("rd_count_unchanged", rd_count0, 16'd3);
    tick();
    bus_idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
